// File: rtl/vram_writer.sv
// vram_writer: bridges the board painter's pixel-write stream to the VGA
// adapter write port. Each frame starts with a full-screen background clear.
// Control then passes to the painter through the cont-signal chain. Painter
// writes are buffered in a small FIFO and drained one pixel per cycle.
// Optional build macro: VRAM_WRITER_OOB_FILTER_EN drops off-screen painter
// writes at push time. When it is not defined, all writes are passed through.
module vram_writer #(
    parameter int         SCR_WIDTH  = 160,
    parameter int         SCR_HEIGHT = 120,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [2:0] BG_COLOR   = 3'b111
) (
    input  logic        Clck,
    input  logic        Reset,
    input  logic        in_cont_signal,
    output logic        out_cont_signal,
    input  logic        next_out_cont_signal,
    input  logic [14:0] wr_address,
    input  logic [2:0]  wr_color,
    input  logic        wr_enable,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int               PTR_W    = $clog2(FIFO_DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [7:0]       X_LAST   = 8'(SCR_WIDTH - 1);
    localparam logic [6:0]       Y_LAST   = 7'(SCR_HEIGHT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_HANDOFF = 2'd2
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [7:0]         clr_x_r;
    logic [6:0]         clr_y_r;
    logic               clr_last_s;

    logic               wr_en_d_r;
    logic               push_edge_s;
    logic               oob_s;
    logic               push_req_s;
    logic               push_ok_s;
    logic               drop_s;
    logic               empty_s;
    logic               full_s;
    logic               drain_en_s;
    logic               pop_s;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_next_s;
    logic [17:0]        fifo_mem_r [FIFO_DEPTH];
    logic [17:0]        rd_entry_s;

    logic               plot_s;
    logic [7:0]         x_s;
    logic [6:0]         y_s;
    logic [2:0]         colour_s;
    logic               out_cont_s;

    // FSM state register
    always_ff @(posedge Clck or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic: idle -> clear sweep -> hand-off to painter -> idle
    always_comb begin
        next_state_s = state_r;
        clr_last_s   = (clr_x_r == X_LAST) && (clr_y_r == Y_LAST);
        case (state_r)
            ST_IDLE: begin
                if (in_cont_signal && !out_cont_signal) begin
                    next_state_s = ST_CLEAR;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_last_s) begin
                    next_state_s = ST_HANDOFF;
                end else begin
                    next_state_s = ST_CLEAR;
                end
            end
            ST_HANDOFF: begin
                if (next_out_cont_signal) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_HANDOFF;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Clear-sweep raster counters: x runs fastest, they are parked at the origin outside the sweep
    always_ff @(posedge Clck or posedge Reset) begin
        if (Reset) begin
            clr_x_r <= 8'd0;
            clr_y_r <= 7'd0;
        end else if (state_r == ST_CLEAR) begin
            if (clr_x_r == X_LAST) begin
                clr_x_r <= 8'd0;
                clr_y_r <= clr_y_r + 7'd1;
            end else begin
                clr_x_r <= clr_x_r + 8'd1;
            end
        end else begin
            clr_x_r <= 8'd0;
            clr_y_r <= 7'd0;
        end
    end

    // Push-side decode: one push per wr_enable rising edge, with optional off-screen filtering
    always_comb begin
        push_edge_s = wr_enable && !wr_en_d_r;
`ifdef VRAM_WRITER_OOB_FILTER_EN
        oob_s = (wr_address[7:0] > X_LAST) || (wr_address[14:8] > Y_LAST);
`else
        oob_s = 1'b0;
`endif
        empty_s      = (count_r == {CNT_W{1'b0}});
        full_s       = (count_r == CNT_FULL);
        drain_en_s   = (state_r == ST_IDLE) || (state_r == ST_HANDOFF);
        pop_s        = drain_en_s && !empty_s;
        push_req_s   = push_edge_s && !oob_s;
        // A full FIFO still accepts a push when an entry leaves in the same cycle
        push_ok_s    = push_req_s && (!full_s || pop_s);
        drop_s       = push_req_s && full_s && !pop_s;
        count_next_s = count_r + CNT_W'(push_ok_s) - CNT_W'(pop_s);
        rd_entry_s   = fifo_mem_r[rd_ptr_r];
    end

    // FIFO control: pointers, occupancy, full flag, sticky overflow and wr_enable edge history
    always_ff @(posedge Clck or posedge Reset) begin
        if (Reset) begin
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            fifo_full <= 1'b0;
            overflow  <= 1'b0;
            wr_en_d_r <= 1'b0;
        end else begin
            wr_en_d_r <= wr_enable;
            count_r   <= count_next_s;
            fifo_full <= (count_next_s == CNT_FULL);
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (drop_s) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO storage: entry layout is {y[6:0], x[7:0], colour[2:0]}
    always_ff @(posedge Clck) begin
        if (push_ok_s) begin
            fifo_mem_r[wr_ptr_r] <= {wr_address, wr_color};
        end
    end

    // FSM output logic: select the clear raster or a drained FIFO entry, else hold the last pixel
    always_comb begin
        plot_s     = 1'b0;
        x_s        = vga_x;
        y_s        = vga_y;
        colour_s   = vga_colour;
        out_cont_s = (next_state_s == ST_HANDOFF);
        case (state_r)
            ST_CLEAR: begin
                plot_s   = 1'b1;
                x_s      = clr_x_r;
                y_s      = clr_y_r;
                colour_s = BG_COLOR;
            end
            ST_IDLE, ST_HANDOFF: begin
                if (pop_s) begin
                    plot_s   = 1'b1;
                    y_s      = rd_entry_s[17:11];
                    x_s      = rd_entry_s[10:3];
                    colour_s = rd_entry_s[2:0];
                end else begin
                    plot_s = 1'b0;
                end
            end
            default: begin
                plot_s = 1'b0;
            end
        endcase
    end

    // Registered adapter port and cont-signal output
    always_ff @(posedge Clck or posedge Reset) begin
        if (Reset) begin
            vga_x           <= 8'd0;
            vga_y           <= 7'd0;
            vga_colour      <= 3'd0;
            vga_plot        <= 1'b0;
            out_cont_signal <= 1'b0;
        end else begin
            vga_x           <= x_s;
            vga_y           <= y_s;
            vga_colour      <= colour_s;
            vga_plot        <= plot_s;
            out_cont_signal <= out_cont_s;
        end
    end

endmodule
